// File: rtl/cartridge_bus_controller.sv
// ---------------------------------------------------------------------------
// cartridge_bus_controller
//
// Sequences single read / write / reset-pulse operations on the Game Boy
// cartridge bus with programmable setup, strobe and hold lengths. One request
// is in flight at a time. Every pin-side output comes straight from a flop.
//
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   req_valid / req_ready       host handshake (accept on valid && ready)
//   req_op                      0 read, 1 write, 2 reset pulse, 3 read
//   req_addr, req_wdata         request address and write data
//   resp_valid, resp_rdata      one-cycle completion pulse, read data
//   cart_a_out / cart_a_oe      address pins and their drive enable
//   cart_d_out / cart_d_oe      data pins (out) and their drive enable
//   cart_d_in                   data pins (in)
//   cart_nrd/nwr/ncs/nrst       active-low cartridge strobes
// ---------------------------------------------------------------------------
module cartridge_bus_controller #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int RESET_CYCLES  = 200
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic [15:0] cart_a_out,
  output logic        cart_a_oe,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in,
  output logic        cart_nrd,
  output logic        cart_nwr,
  output logic        cart_ncs,
  output logic        cart_nrst
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RST
  } state_t;

  // The counter is loaded with (length - 1) on state entry and the state
  // advances when it reads 0, so each phase lasts exactly its length.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] RST_LD    = 8'(RESET_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        is_write_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [7:0]  rdata_q;
  logic [15:0] a_out_q;
  logic        a_oe_q;
  logic [7:0]  d_out_q;
  logic        d_oe_q;
  logic        nrd_q;
  logic        nwr_q;
  logic        ncs_q;
  logic        nrst_q;

  // External RAM window 0xA000-0xBFFF is the only region selected by nCS.
  logic cs_hit;
  assign cs_hit = (req_addr[15:13] == 3'b101);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      is_write_q   <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 8'h00;
      a_out_q      <= 16'h0000;
      a_oe_q       <= 1'b0;
      d_out_q      <= 8'h00;
      d_oe_q       <= 1'b0;
      nrd_q        <= 1'b1;
      nwr_q        <= 1'b1;
      ncs_q        <= 1'b1;
      nrst_q       <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          // ready_q is only ever high in IDLE, so it doubles as the accept gate
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            if (req_op == 2'd2) begin
              state_q <= ST_RST;
              cnt_q   <= RST_LD;
              nrst_q  <= 1'b0;
            end else begin
              state_q    <= ST_SETUP;
              cnt_q      <= SETUP_LD;
              is_write_q <= (req_op == 2'd1);
              a_out_q    <= req_addr;
              a_oe_q     <= 1'b1;
              ncs_q      <= ~cs_hit;
              if (req_op == 2'd1) begin
                d_out_q <= req_wdata;
                d_oe_q  <= 1'b1;
              end else begin
                // Reads assert nRD from the first SETUP cycle onward
                nrd_q  <= 1'b0;
                d_oe_q <= 1'b0;
              end
            end
          end
        end

        ST_SETUP: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_STROBE;
            cnt_q   <= STROBE_LD;
            if (is_write_q) begin
              nwr_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        ST_STROBE: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LD;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            ncs_q   <= 1'b1;
            // Sample the bus on the edge that closes the strobe
            if (!is_write_q) begin
              rdata_q <= cart_d_in;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            d_oe_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        ST_RST: begin
          if (cnt_q == 8'd0) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            nrst_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign cart_a_out = a_out_q;
  assign cart_a_oe  = a_oe_q;
  assign cart_d_out = d_out_q;
  assign cart_d_oe  = d_oe_q;
  assign cart_nrd   = nrd_q;
  assign cart_nwr   = nwr_q;
  assign cart_ncs   = ncs_q;
  assign cart_nrst  = nrst_q;

endmodule

// File: tb/tb_cartridge_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_cartridge_bus_controller
//
// Drives operations into cartridge_bus_controller and compares every pin in
// every cycle of each operation against a cycle-range model derived from the
// bus timing rules. A simple cartridge memory answers reads and latches writes.
// ---------------------------------------------------------------------------
module tb_cartridge_bus_controller;

  localparam int S_C = 2;
  localparam int T_C = 4;
  localparam int H_C = 2;
  localparam int R_C = 200;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic [15:0] cart_a_out;
  logic        cart_a_oe;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic [7:0]  cart_d_in;
  logic        cart_nrd;
  logic        cart_nwr;
  logic        cart_ncs;
  logic        cart_nrst;

  cartridge_bus_controller #(
    .SETUP_CYCLES (S_C),
    .STROBE_CYCLES(T_C),
    .HOLD_CYCLES  (H_C),
    .RESET_CYCLES (R_C)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .cart_a_out(cart_a_out),
    .cart_a_oe (cart_a_oe),
    .cart_d_out(cart_d_out),
    .cart_d_oe (cart_d_oe),
    .cart_d_in (cart_d_in),
    .cart_nrd  (cart_nrd),
    .cart_nwr  (cart_nwr),
    .cart_ncs  (cart_ncs),
    .cart_nrst (cart_nrst)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Snapshot of every observable output in one cycle
  typedef struct packed {
    logic        ready;
    logic        resp;
    logic [7:0]  rdata;
    logic [15:0] a;
    logic        a_oe;
    logic [7:0]  d;
    logic        d_oe;
    logic        nrd;
    logic        nwr;
    logic        ncs;
    logic        nrst;
  } pins_t;

  localparam pins_t RST_PINS = '{ready: 1'b0, resp: 1'b0, rdata: 8'h00, a: 16'h0000,
                                 a_oe: 1'b0, d: 8'h00, d_oe: 1'b0, nrd: 1'b1,
                                 nwr: 1'b1, ncs: 1'b1, nrst: 1'b1};

  // Cartridge memory model: answers reads while nRD is low, latches writes
  // while nWR is low
  bit [7:0] cart_mem [0:65535];
  assign cart_d_in = cart_nrd ? 8'hFF : cart_mem[cart_a_out];
  always @(negedge clock) begin
    if (!cart_nwr && cart_d_oe) cart_mem[cart_a_out] = cart_d_out;
  end

  // Reference contents: power-up pattern plus every completed write
  bit [7:0] written [bit [15:0]];

  function automatic bit [7:0] init_byte(input bit [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic bit [7:0] ref_read(input bit [15:0] a);
    if (written.exists(a)) return written[a];
    return init_byte(a);
  endfunction

  // Idle-state view of the controller as the model believes it
  logic [15:0] m_a;
  logic        m_aoe;
  logic [7:0]  m_d;
  logic [7:0]  m_rdata;

  int tests_run;
  int tests_failed;

  pins_t obs [0:255];
  int    obs_len;

  function automatic pins_t sample();
    pins_t p;
    p = {req_ready, resp_valid, resp_rdata, cart_a_out, cart_a_oe, cart_d_out,
         cart_d_oe, cart_nrd, cart_nwr, cart_ncs, cart_nrst};
    return p;
  endfunction

  // Expected pins in cycle k (accept = cycle 0) of an operation
  function automatic pins_t model_pins(input logic [1:0] op, input logic [15:0] addr,
                                       input logic [7:0] wd, input int k);
    pins_t p;
    int    len;
    bit    active;
    len     = (op == 2'd2) ? R_C : S_C + T_C + H_C;
    p       = RST_PINS;
    p.ready = (k == len + 1);
    p.resp  = (k == len + 1);
    p.rdata = m_rdata;
    p.a     = m_a;
    p.a_oe  = m_aoe;
    p.d     = m_d;
    if (op == 2'd2) begin
      p.nrst = (k > R_C);
    end else begin
      active = (k <= S_C + T_C);
      p.a    = addr;
      p.a_oe = 1'b1;
      if (active && addr[15:13] == 3'b101) p.ncs = 1'b0;
      if (op == 2'd1) begin
        p.d    = wd;
        p.d_oe = (k <= len);
        p.nwr  = !(k > S_C && active);
      end else begin
        p.nrd = !active;
        if (!active) p.rdata = ref_read(addr);
      end
    end
    return p;
  endfunction

  task automatic model_commit(input logic [1:0] op, input logic [15:0] addr,
                              input logic [7:0] wd);
    if (op != 2'd2) begin
      m_a   = addr;
      m_aoe = 1'b1;
      if (op == 2'd1) begin
        m_d          = wd;
        written[addr] = wd;
      end else begin
        m_rdata = ref_read(addr);
      end
    end
  endtask

  task automatic model_reset();
    m_a     = 16'h0000;
    m_aoe   = 1'b0;
    m_d     = 8'h00;
    m_rdata = 8'h00;
  endtask

  // Presents one request in the current cycle (called just after a negedge
  // with the controller ready) and records the pins for every following cycle
  // up to the response. With keep set, a second request stays valid while busy.
  task automatic run_op(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                        input bit keep, input logic [1:0] nop, input logic [15:0] naddr,
                        input logic [7:0] nwd);
    int n;
    n       = (op == 2'd2) ? R_C : S_C + T_C + H_C;
    obs_len = n + 2;
    obs[0]  = sample();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clock);
      obs[k] = sample();
      if (k == 1) begin
        if (keep) begin
          req_op    = nop;
          req_addr  = naddr;
          req_wdata = nwd;
        end else begin
          req_valid = 1'b0;
          req_op    = 2'($urandom);
          req_addr  = 16'($urandom);
          req_wdata = 8'($urandom);
        end
      end
    end
    $display("[TB] txn op=%0d addr=0x%04h wdata=0x%02h resp_rdata=0x%02h",
             op, addr, wd, obs[n + 1].rdata);
  endtask

  task automatic test_reset();
    pins_t p;
    pins_t e;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    p = sample();
    tests_run++;
    if (p !== RST_PINS) begin
      tests_failed++;
      $display("FAIL reset_values got=%h exp=%h", p, RST_PINS);
    end
    reset_n = 1'b1;
    @(negedge clock);
    p = sample();
    e = RST_PINS;
    e.ready = 1'b1;
    tests_run++;
    if (p !== e) begin
      tests_failed++;
      $display("FAIL reset_release got=%h exp=%h", p, e);
    end
  endtask

  task automatic test_read();
    pins_t e;
    cart_mem[16'h0134] = 8'h4E;
    written[16'h0134]  = 8'h4E;
    run_op(2'd0, 16'h0134, 8'h00, 1'b0, 2'd0, 16'h0, 8'h0);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd0, 16'h0134, 8'h00, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL read_0134 cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    tests_run++;
    if (obs[9].rdata !== 8'h4E || obs[9].resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_0134_data got=%h/%b exp=4e/1", obs[9].rdata, obs[9].resp);
    end
    model_commit(2'd0, 16'h0134, 8'h00);
  endtask

  task automatic test_write();
    pins_t e;
    run_op(2'd1, 16'h2000, 8'h05, 1'b0, 2'd0, 16'h0, 8'h0);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd1, 16'h2000, 8'h05, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL write_2000 cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    model_commit(2'd1, 16'h2000, 8'h05);
  endtask

  task automatic test_back_to_back();
    pins_t e;
    run_op(2'd1, 16'hA123, 8'h77, 1'b0, 2'd0, 16'h0, 8'h0);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd1, 16'hA123, 8'h77, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL b2b_write cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    model_commit(2'd1, 16'hA123, 8'h77);
    // Issued in the write's response cycle
    run_op(2'd0, 16'hA123, 8'h00, 1'b0, 2'd0, 16'h0, 8'h0);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd0, 16'hA123, 8'h00, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL b2b_read cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    tests_run++;
    if (obs[obs_len - 1].rdata !== 8'h77) begin
      tests_failed++;
      $display("FAIL b2b_readback got=%h exp=77", obs[obs_len - 1].rdata);
    end
    model_commit(2'd0, 16'hA123, 8'h00);
  endtask

  task automatic test_reset_pulse();
    pins_t e;
    int    low_cnt;
    run_op(2'd2, 16'h1111, 8'h22, 1'b0, 2'd0, 16'h0, 8'h0);
    low_cnt = 0;
    for (int k = 1; k < obs_len; k++) begin
      if (obs[k].nrst === 1'b0) low_cnt++;
      e = model_pins(2'd2, 16'h1111, 8'h22, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL reset_pulse cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    tests_run++;
    if (low_cnt != R_C) begin
      tests_failed++;
      $display("FAIL reset_pulse_len got=%0d exp=%0d", low_cnt, R_C);
    end
    model_commit(2'd2, 16'h1111, 8'h22);
  endtask

  task automatic test_busy_valid();
    pins_t e;
    run_op(2'd0, 16'h4000, 8'h00, 1'b1, 2'd0, 16'h5555, 8'hAA);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd0, 16'h4000, 8'h00, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL busy_first cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    model_commit(2'd0, 16'h4000, 8'h00);
    run_op(2'd0, 16'h5555, 8'hAA, 1'b0, 2'd0, 16'h0, 8'h0);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd0, 16'h5555, 8'hAA, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL busy_second cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    model_commit(2'd0, 16'h5555, 8'hAA);
  endtask

  task automatic test_async_reset();
    pins_t p;
    pins_t e;
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_addr  = 16'hB010;
    req_wdata = 8'h3C;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (S_C + 1) @(negedge clock);
    tests_run++;
    if (cart_nwr !== 1'b0 || cart_ncs !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_in_strobe nwr=%b ncs=%b exp=0/0", cart_nwr, cart_ncs);
    end
    #1 reset_n = 1'b0;
    #1;
    p = sample();
    tests_run++;
    if (p !== RST_PINS) begin
      tests_failed++;
      $display("FAIL abort_immediate got=%h exp=%h", p, RST_PINS);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      p = sample();
      tests_run++;
      if (p !== RST_PINS) begin
        tests_failed++;
        $display("FAIL abort_held cyc=%0d got=%h exp=%h", k, p, RST_PINS);
      end
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    p = sample();
    e = RST_PINS;
    e.ready = 1'b1;
    tests_run++;
    if (p !== e) begin
      tests_failed++;
      $display("FAIL abort_release got=%h exp=%h", p, e);
    end
    $display("[TB] txn op=1 addr=0xb010 wdata=0x3c aborted by reset");
    run_op(2'd0, 16'h1234, 8'h00, 1'b0, 2'd0, 16'h0, 8'h0);
    for (int k = 1; k < obs_len; k++) begin
      e = model_pins(2'd0, 16'h1234, 8'h00, k);
      tests_run++;
      if (obs[k] !== e) begin
        tests_failed++;
        $display("FAIL abort_next_read cyc=%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    model_commit(2'd0, 16'h1234, 8'h00);
  endtask

  task automatic test_random();
    pins_t       e;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      op = (r < 6) ? 2'd0 : (r < 12) ? 2'd1 : (r < 14) ? 2'd3 : 2'd2;
      addr = 16'($urandom);
      if ($urandom_range(0, 1) == 0) addr[15:13] = 3'b101;
      // This address was hit by an aborted write; keep the reference simple
      if (addr == 16'hB010) addr = 16'hB011;
      wd = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_op(op, addr, wd, 1'b0, 2'd0, 16'h0, 8'h0);
      for (int k = 1; k < obs_len; k++) begin
        e = model_pins(op, addr, wd, k);
        tests_run++;
        if (obs[k] !== e) begin
          tests_failed++;
          $display("FAIL random n=%0d op=%0d cyc=%0d got=%h exp=%h", n, op, k, obs[k], e);
        end
      end
      model_commit(op, addr, wd);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 65536; i++) cart_mem[i] = init_byte(16'(i));
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_pulse();
    test_busy_valid();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
